// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU issue controller.
// Op codes, DSP48E1 control words, in-flight pipe entry.
package alu_ctrl_pkg;

  localparam int ENTRY_RD_W = 5;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_MUL   = 3'd5;
  localparam logic [2:0] OP_PASSC = 3'd6;
  localparam logic [2:0] OP_NOP   = 3'd7;

  localparam logic [6:0] OPM_ZERO  = 7'b0000000;
  localparam logic [6:0] OPM_ARITH = 7'b0110011;
  localparam logic [6:0] OPM_OR    = 7'b0111011;
  localparam logic [6:0] OPM_MUL   = 7'b0000101;
  localparam logic [6:0] OPM_PASSC = 7'b0110000;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0011;
  localparam logic [3:0] ALU_LOGIC = 4'b1100;
  localparam logic [3:0] ALU_XOR   = 4'b0100;

  localparam logic [4:0] INM_DEF = 5'b00000;

  typedef struct packed {
    logic [6:0] opmode;
    logic [3:0] alumode;
    logic [4:0] inmode;
    logic       usemult;
    logic       writes;
  } dec_t;

  typedef struct packed {
    logic                  valid;
    logic [ENTRY_RD_W-1:0] rd;
  } inflight_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    IDLE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// Op code to DSP48E1 control word decoder.
// Purely combinational; NOP decodes with writes=0.
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [2:0] op_code,
  output dec_t       dec
);

  // map each op code onto OPMODE/ALUMODE/USE_MULT
  always_comb begin
    dec = '{opmode: OPM_ZERO, alumode: ALU_ADD,
            inmode: INM_DEF, usemult: 1'b0,
            writes: 1'b1};
    unique case (op_code)
      OP_ADD:   dec.opmode = OPM_ARITH;
      OP_SUB: begin
        dec.opmode  = OPM_ARITH;
        dec.alumode = ALU_SUB;
      end
      OP_AND: begin
        dec.opmode  = OPM_ARITH;
        dec.alumode = ALU_LOGIC;
      end
      OP_OR: begin
        dec.opmode  = OPM_OR;
        dec.alumode = ALU_LOGIC;
      end
      OP_XOR: begin
        dec.opmode  = OPM_ARITH;
        dec.alumode = ALU_XOR;
      end
      OP_MUL: begin
        dec.opmode  = OPM_MUL;
        dec.usemult = 1'b1;
      end
      OP_PASSC: dec.opmode = OPM_PASSC;
      OP_NOP:   dec.writes = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the DSP48E1 execution unit.
// Optional perf counters: define ALU_ISSUE_CTRL_PERF_EN.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int         LATENCY    = 4,
  parameter int         RADDR_W    = ENTRY_RD_W,
  parameter logic [6:0] NOP_OPMODE = 7'b0000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid_i,
  output logic               op_ready_o,
  input  logic [2:0]         op_code_i,
  input  logic [RADDR_W-1:0] rd_i,
  input  logic [RADDR_W-1:0] rs1_i,
  input  logic [RADDR_W-1:0] rs2_i,
  input  logic [1:0]         rs_used_i,
  input  logic               flush_i,
  input  logic               quiesce_i,
  output logic               idle_o,
  output logic [6:0]         opmode_o,
  output logic [3:0]         alumode_o,
  output logic [4:0]         inmode_o,
  output logic               usemult_o,
  output logic               cea2_o,
  output logic               ceb2_o,
  output logic               wb_valid_o,
  output logic [RADDR_W-1:0] wb_rd_o
`ifdef ALU_ISSUE_CTRL_PERF_EN
  ,
  output logic [31:0]        issue_cnt_o,
  output logic [31:0]        stall_cnt_o
`endif
);

  // last pipe stage is the wb register itself
  localparam int DEPTH = LATENCY - 1;

  if (RADDR_W != ENTRY_RD_W) begin : g_bad_w
    $error("RADDR_W must equal ENTRY_RD_W");
  end

  dec_t      dec;
  inflight_t pipe [DEPTH];
  state_t    state, state_nxt;
  logic      stall, accept, empty;

  alu_op_decode u_dec (
    .op_code (op_code_i),
    .dec     (dec)
  );

  // RAW hazard against entries not yet written back
  always_comb begin
    stall = 1'b0;
    empty = ~wb_valid_o;
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe[i].valid) begin
        empty = 1'b0;
        if (pipe[i].rd != '0 &&
            ((rs_used_i[0] && pipe[i].rd == rs1_i) ||
             (rs_used_i[1] && pipe[i].rd == rs2_i)))
          stall = 1'b1;
      end
    end
  end

  assign op_ready_o = (state == RUN) & ~stall & ~flush_i;
  assign accept     = op_valid_i & op_ready_o;

  // DSP control words, idle unless an op issues
  always_comb begin
    opmode_o  = NOP_OPMODE;
    alumode_o = '0;
    inmode_o  = '0;
    usemult_o = 1'b0;
    cea2_o    = 1'b0;
    ceb2_o    = 1'b0;
    if (accept) begin
      opmode_o  = dec.writes ? dec.opmode : NOP_OPMODE;
      alumode_o = dec.alumode;
      inmode_o  = dec.inmode;
      usemult_o = dec.usemult;
      cea2_o    = 1'b1;
      ceb2_o    = 1'b1;
    end
  end

  // quiesce FSM next state and idle flag
  always_comb begin
    state_nxt = state;
    idle_o    = 1'b0;
    unique case (state)
      RUN:
        if (quiesce_i) state_nxt = DRAIN;
      DRAIN:
        if (empty) begin
          idle_o    = 1'b1;
          state_nxt = IDLE;
        end
      IDLE: begin
        idle_o = 1'b1;
        if (!quiesce_i) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // in-flight shift pipe and aligned writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        pipe[i] <= '0;
      wb_valid_o <= 1'b0;
      wb_rd_o    <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++)
        pipe[i] <= '0;
      wb_valid_o <= 1'b0;
    end else begin
      pipe[0].valid <= accept & dec.writes;
      pipe[0].rd    <= accept ? rd_i : '0;
      for (int i = 1; i < DEPTH; i++)
        pipe[i] <= pipe[i-1];
      wb_valid_o <= pipe[DEPTH-1].valid;
      wb_rd_o    <= pipe[DEPTH-1].rd;
    end
  end

`ifdef ALU_ISSUE_CTRL_PERF_EN
  // saturating issue and stall counters
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (accept && dec.writes && ~&issue_cnt_o)
        issue_cnt_o <= issue_cnt_o + 32'd1;
      if (op_valid_i && stall && ~&stall_cnt_o)
        stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed ops, queued
// writeback expectations popped by a monitor.
module tb_alu_issue_ctrl;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid_i, op_ready_o;
  logic [2:0] op_code_i;
  logic [4:0] rd_i, rs1_i, rs2_i;
  logic [1:0] rs_used_i;
  logic       flush_i, quiesce_i, idle_o;
  logic [6:0] opmode_o;
  logic [3:0] alumode_o;
  logic [4:0] inmode_o;
  logic       usemult_o, cea2_o, ceb2_o;
  logic       wb_valid_o;
  logic [4:0] wb_rd_o;
`ifdef ALU_ISSUE_CTRL_PERF_EN
  logic [31:0] issue_cnt_o, stall_cnt_o;
`endif

  alu_issue_ctrl #(.LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid_i (op_valid_i),
    .op_ready_o (op_ready_o),
    .op_code_i  (op_code_i),
    .rd_i       (rd_i),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .rs_used_i  (rs_used_i),
    .flush_i    (flush_i),
    .quiesce_i  (quiesce_i),
    .idle_o     (idle_o),
    .opmode_o   (opmode_o),
    .alumode_o  (alumode_o),
    .inmode_o   (inmode_o),
    .usemult_o  (usemult_o),
    .cea2_o     (cea2_o),
    .ceb2_o     (ceb2_o),
    .wb_valid_o (wb_valid_o),
    .wb_rd_o    (wb_rd_o)
`ifdef ALU_ISSUE_CTRL_PERF_EN
    ,
    .issue_cnt_o(issue_cnt_o),
    .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0] rd;
    int         at;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d",
               nm, act, req, cyc);
    end
  endtask

  // writeback monitor / scoreboard
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].at < cyc) begin
      exp_t m;
      m = q.pop_front();
      chk("wb_missing_at", 32'(m.at), 32'(cyc));
    end
    if (wb_valid_o) begin
      if (q.size() == 0) begin
        chk("wb_unexpected", 32'(wb_rd_o), 32'h1f);
        chk("wb_unexpected_v", 32'(wb_valid_o), 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wb_rd", 32'(wb_rd_o), 32'(e.rd));
        chk("wb_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] c,
                    input logic [4:0] rd,
                    input logic [4:0] r1,
                    input logic [4:0] r2,
                    input logic [1:0] u);
    op_valid_i = 1'b1;
    op_code_i  = c;
    rd_i       = rd;
    rs1_i      = r1;
    rs2_i      = r2;
    rs_used_i  = u;
  endtask

  task automatic no_op();
    op_valid_i = 1'b0;
    op_code_i  = 3'd7;
    rs_used_i  = 2'b00;
  endtask

  // drive op, expect accept with given controls
  task automatic send(input string nm,
                      input logic [2:0] c,
                      input logic [4:0] rd,
                      input logic [4:0] r1,
                      input logic [4:0] r2,
                      input logic [1:0] u,
                      input logic [6:0] opm,
                      input logic [3:0] alu,
                      input logic       um,
                      input bit         push);
    op(c, rd, r1, r2, u);
    #1;
    chk({nm, "_ready"}, 32'(op_ready_o), 1);
    chk({nm, "_opmode"}, 32'(opmode_o), 32'(opm));
    chk({nm, "_alumode"}, 32'(alumode_o), 32'(alu));
    chk({nm, "_usemult"}, 32'(usemult_o), 32'(um));
    chk({nm, "_inmode"}, 32'(inmode_o), 0);
    chk({nm, "_ce"}, 32'({cea2_o, ceb2_o}), 3);
    if (push) q.push_back('{rd, cyc + LAT});
  endtask

  localparam logic [6:0] AR = 7'b0110011;

  initial begin
    int n;
    int tq;
    rst = 1'b1;
    flush_i = 1'b0;
    quiesce_i = 1'b0;
    rd_i = '0;
    rs1_i = '0;
    rs2_i = '0;
    no_op();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_ready", 32'(op_ready_o), 1);
    chk("rst_idle", 32'(idle_o), 0);
    chk("rst_wbv", 32'(wb_valid_o), 0);
    chk("rst_wbrd", 32'(wb_rd_o), 0);
    chk("rst_opmode", 32'(opmode_o), 0);
    chk("rst_ce", 32'({cea2_o, ceb2_o}), 0);

    // decode of every op, back to back
    tick(); send("add", 0, 3, 0, 0, 0, AR, 4'b0000, 0, 1);
    tick(); send("mul", 5, 4, 0, 0, 0, 7'b0000101, 0, 1, 1);
    tick(); send("sub", 1, 5, 1, 2, 3, AR, 4'b0011, 0, 1);
    tick(); send("and", 2, 6, 0, 0, 0, AR, 4'b1100, 0, 1);
    tick(); send("or", 3, 8, 0, 0, 0, 7'b0111011, 4'b1100, 0, 1);
    tick(); send("xor", 4, 9, 0, 0, 0, AR, 4'b0100, 0, 1);
    tick(); send("passc", 6, 10, 0, 0, 0, 7'b0110000, 0, 0, 1);
    tick(); send("nop", 7, 11, 0, 0, 0, 7'b0, 0, 0, 0);
    tick(); no_op();
    #1 chk("idle_opmode", 32'(opmode_o), 0);
    repeat (6) tick();

    // RAW hazard: 3 stall cycles then accept
    send("haz_add", 0, 7, 0, 0, 0, AR, 0, 0, 1);
    tick(); op(4, 12, 7, 0, 1);
    for (int k = 0; k < 3; k++) begin
      #1 chk("haz_stall", 32'(op_ready_o), 0);
      chk("haz_ce", 32'(cea2_o), 0);
      tick();
    end
    send("haz_rel", 4, 12, 7, 0, 1, AR, 4'b0100, 0, 1);
    tick(); send("add_r0", 0, 0, 0, 0, 0, AR, 0, 0, 1);
    tick(); send("r0_src", 3, 13, 0, 0, 3, 7'b0111011, 4'b1100, 0, 1);
    tick(); no_op();
    repeat (6) tick();

    // flush kills two in-flight ops
    send("fl_a", 0, 14, 0, 0, 0, AR, 0, 0, 0);
    tick(); send("fl_b", 0, 15, 0, 0, 0, AR, 0, 0, 0);
    tick(); op(0, 16, 0, 0, 0);
    flush_i = 1'b1;
    #1 chk("flush_block", 32'(op_ready_o), 0);
    chk("flush_ce", 32'(cea2_o), 0);
    tick(); flush_i = 1'b0;
    send("post_flush", 0, 17, 0, 0, 0, AR, 0, 0, 1);
    tick(); no_op();
    repeat (6) tick();

    // quiesce with three ops in flight
    send("q_a", 0, 18, 0, 0, 0, AR, 0, 0, 1);
    tick(); send("q_b", 0, 19, 0, 0, 0, AR, 0, 0, 1);
    tick(); quiesce_i = 1'b1;
    send("q_c", 0, 20, 0, 0, 0, AR, 0, 0, 1);
    tq = cyc;
    tick(); op(0, 21, 0, 0, 0);
    #1 chk("drain_block", 32'(op_ready_o), 0);
    chk("drain_noidle", 32'(idle_o), 0);
    no_op();
    n = 0;
    while (!idle_o && n < 20) begin
      tick();
      n++;
    end
    chk("drain_idle", 32'(idle_o), 1);
    chk("drain_idle_cyc", 32'(cyc), 32'(tq + 5));
    tick();
    chk("idle_hold", 32'(idle_o), 1);
    chk("idle_ready", 32'(op_ready_o), 0);
    quiesce_i = 1'b0;
    tick();
    chk("resume_ready", 32'(op_ready_o), 1);
    chk("resume_idle", 32'(idle_o), 0);

    // flush during drain empties the pipe
    send("fd_a", 0, 22, 0, 0, 0, AR, 0, 0, 0);
    tick(); no_op(); quiesce_i = 1'b1;
    tick(); flush_i = 1'b1;
    #1 chk("fd_noidle", 32'(idle_o), 0);
    tick(); flush_i = 1'b0;
    chk("fd_idle", 32'(idle_o), 1);
    quiesce_i = 1'b0;
    tick(); tick();
    chk("fd_resume", 32'(op_ready_o), 1);

    // reset mid-flight discards results
    send("rs_a", 0, 23, 0, 0, 0, AR, 0, 0, 0);
    tick(); no_op(); rst = 1'b1;
    tick(); rst = 1'b0;
    #1 chk("rs_ready", 32'(op_ready_o), 1);
    chk("rs_wbv", 32'(wb_valid_o), 0);
    repeat (6) tick();

    // 5 issues with 3 stall cycles
    send("pf_a", 0, 24, 0, 0, 0, AR, 0, 0, 1);
    tick(); op(4, 25, 0, 24, 2);
    for (int k = 0; k < 3; k++) begin
      #1 chk("pf_stall", 32'(op_ready_o), 0);
      tick();
    end
    send("pf_b", 4, 25, 0, 24, 2, AR, 4'b0100, 0, 1);
    tick(); send("pf_c", 2, 26, 0, 0, 0, AR, 4'b1100, 0, 1);
    tick(); send("pf_d", 3, 27, 0, 0, 0, 7'b0111011, 4'b1100, 0, 1);
    tick(); send("pf_e", 1, 28, 0, 0, 0, AR, 4'b0011, 0, 1);
    tick(); no_op();
`ifdef ALU_ISSUE_CTRL_PERF_EN
    #1 chk("issue_cnt", issue_cnt_o, 5);
    chk("stall_cnt", stall_cnt_o, 3);
`endif
    repeat (8) tick();
    chk("sb_empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Issue controller and scheduler for the DSP48E1-based execution unit (alu_core). It accepts decoded micro-ops over a valid/ready handshake and translates each op code into the DSP control words (OPMODE, ALUMODE, INMODE, USE_MULT select, CEA2/CEB2). It tracks every in-flight op through the fixed-latency pipeline, stalls read-after-write hazards, and emits aligned writeback valid/destination for the register file. It also supports flush and a quiesce/drain handshake for the pipeline control unit.

Parameters:
LATENCY, 4, cycles from op acceptance to P valid at alu_core output; legal range 2..8
RADDR_W, 5, register address width
NOP_OPMODE, 7'b0000000, OPMODE driven when no op issues (P <= 0)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
op_valid_i  in  1  micro-op present
op_ready_o  out  1  controller can accept op this cycle
op_code_i  in  3  0=ADD 1=SUB 2=AND 3=OR 4=XOR 5=MUL 6=PASSC 7=NOP
rd_i  in  RADDR_W  destination register
rs1_i  in  RADDR_W  source 1
rs2_i  in  RADDR_W  source 2
rs_used_i  in  2  bit0: rs1 read, bit1: rs2 read
flush_i  in  1  kill all in-flight ops
quiesce_i  in  1  stop accepting, drain pipeline
idle_o  out  1  pipeline empty while quiescing
opmode_o  out  7  to alu_core opmode_i
alumode_o  out  4  to alu_core alumode_i
inmode_o  out  5  to alu_core inmode_i
usemult_o  out  1  to alu_core usemult_i
cea2_o  out  1  to alu_core cea2_i
ceb2_o  out  1  to alu_core ceb2_i
wb_valid_o  out  1  P result valid, write regfile
wb_rd_o  out  RADDR_W  destination for current P

Behaviour:
- Reset: FSM=RUN; in-flight valid pipe cleared; wb_valid_o=0, wb_rd_o=0, idle_o=0; op_ready_o=1 on the cycle after reset deasserts.
- accept = op_valid_i & op_ready_o. Control outputs are combinational from op_code_i when accept=1. Otherwise opmode_o=NOP_OPMODE, alumode_o=0, inmode_o=0, usemult_o=0, cea2_o=ceb2_o=0.
- Decode (opmode/alumode/usemult): ADD 0110011/0000/0; SUB (C-A:B) 0110011/0011/0; AND 0110011/1100/0; OR 0111011/1100/0; XOR 0110011/0100/0; MUL 0000101/0000/1; PASSC 0110000/0000/0. inmode_o=00000 for all ops. cea2_o=ceb2_o=1 on every accept.
- NOP (code 7): accepted and consumes a slot, with no writeback.
- In-flight pipe: shift register of LATENCY entries {valid, rd}. The entry entered on accept (valid=0 for NOP) reaches the end at T+LATENCY. wb_valid_o/wb_rd_o are registered from the last entry, so an op accepted at cycle T writes back in cycle T+LATENCY.
- Hazard: stall when any valid in-flight entry whose writeback has not yet been presented satisfies rd==rs1_i (if rs_used_i[0]) or rd==rs2_i (if rs_used_i[1]). rd==0 is never a hazard.
- op_ready_o = (state==RUN) & ~stall & ~flush_i.
- Back-to-back independent ops issue every cycle (full throughput).
- FSM states:
  - RUN -> DRAIN on quiesce_i.
  - DRAIN: op_ready_o=0 until all entries are invalid, then idle_o=1 and go to IDLE.
  - IDLE -> RUN when quiesce_i falls; idle_o=0 in RUN.
- flush_i: in the same cycle, no accept; on the next edge every in-flight valid bit and wb_valid_o are cleared. Flush during DRAIN makes the pipe empty, so idle_o asserts on the following cycle.
- Flush and accept in the same cycle: flush wins.
- rst mid-operation: all in-flight results are discarded, with no writeback.

Optional Feature:
ALU_ISSUE_CTRL_PERF_EN: when defined, adds outputs issue_cnt_o[31:0] and stall_cnt_o[31:0].
- issue_cnt_o increments on each non-NOP accept.
- stall_cnt_o increments each cycle op_valid_i & stall.
- Both counters saturate at 32'hFFFFFFFF and clear on rst.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
Package alu_ctrl_pkg holds:
- op code localparams;
- OPMODE/ALUMODE/INMODE constants per op;
- the {valid, rd} in-flight entry typedef.

Sub-module alu_op_decode: purely combinational op_code -> {opmode, alumode, inmode, usemult, writes}.

Test Plan:
- Reset then ADD rd=3 at cycle 10 -> opmode_o=0110011, alumode_o=0000, cea2_o=ceb2_o=1 at cycle 10; wb_valid_o=1, wb_rd_o=3 at cycle 14.
- MUL rd=4, then independent SUB rd=5 next cycle -> usemult_o=1 then 0, alumode_o=0011; writebacks in cycles T+4 and T+5.
- ADD rd=7, then XOR rs1=7 -> op_ready_o=0 for 3 cycles; XOR is accepted in the cycle its hazard clears; rs1=0 with rd=0 in flight never stalls.
- Two ops in flight, flush_i pulse -> no wb_valid_o afterwards; next op is accepted the cycle after flush.
- quiesce_i with 3 ops in flight -> op_ready_o=0, three writebacks, then idle_o=1; drop quiesce_i -> op_ready_o=1.
- With ALU_ISSUE_CTRL_PERF_EN: 5 ops plus a 3-cycle stall -> issue_cnt_o=5, stall_cnt_o=3.
